// File: rtl/CPU_pkg.sv
// Shared types and constants for the Aurora RISC-V pipeline.
package CPU_pkg;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_t;

    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
    localparam logic [31:0] INST_NOP      = 32'h00000013;
    localparam logic [2:0]  IMEM_ARPROT   = 3'b100;

    // A faulted fetch presents a NOP so only the bus exception travels down the pipe.
    function automatic logic [31:0] fetch_word(input logic [31:0] rdata,
                                               input logic [1:0]  rresp);
        return (rresp == AXI_RESP_OKAY) ? rdata : INST_NOP;
    endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: PC, single-outstanding AXI4-Lite read master and the IF/ID register.
module if_stage
    import CPU_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h00000000,
    parameter logic [2:0]  ARPROT    = IMEM_ARPROT
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [31:0] PC_IF,
    output logic [31:0] IR_IF,
    output logic [1:0]  imem_axi_rresp_IF,
    input  logic        jump_ena,
    input  logic [31:0] jump_addr,
    output logic [31:0] imem_axi_araddr,
    output logic [2:0]  imem_axi_arprot,
    output logic        imem_axi_arvalid,
    input  logic        imem_axi_arready,
    input  logic [31:0] imem_axi_rdata,
    input  logic [1:0]  imem_axi_rresp,
    input  logic        imem_axi_rvalid,
    output logic        imem_axi_rready
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_araddr;
    logic         r_arvalid;
    logic         r_drop;
    logic         r_valid;
    logic [31:0]  r_pc_if;
    logic [31:0]  r_ir_if;
    logic [1:0]   r_rresp;

    logic         w_rready;
    logic         w_r_hs;
    logic         w_load;
    logic [31:0]  w_jump_pc;

    // A stale beat is always accepted so the single outstanding slot frees up.
    assign w_rready  = (r_state == S_WAIT) & (r_drop | ~r_valid | ready_in);
    assign w_r_hs    = imem_axi_rvalid & w_rready;
    assign w_load    = w_r_hs & ~r_drop & ~jump_ena;
    assign w_jump_pc = {jump_addr[31:2], 2'b00};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_REQ;
            r_pc      <= RESET_VEC;
            r_araddr  <= 32'h0;
            r_arvalid <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (!r_arvalid) begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= jump_ena ? w_jump_pc : r_pc;
                    end else begin
                        if (imem_axi_arready) begin
                            r_arvalid <= 1'b0;
                            r_state   <= S_WAIT;
                            // The address of a stale request is not the PC, so do not advance.
                            if (!r_drop) begin
                                r_pc <= r_pc + 32'd4;
                            end
                        end
                        if (jump_ena) begin
                            r_drop <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_r_hs) begin
                        r_state   <= S_REQ;
                        r_arvalid <= 1'b1;
                        r_drop    <= 1'b0;
                        r_araddr  <= jump_ena ? w_jump_pc : r_pc;
                    end else if (jump_ena) begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
            if (jump_ena) begin
                r_pc <= w_jump_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_pc_if <= 32'h0;
            r_ir_if <= 32'h0;
            r_rresp <= AXI_RESP_OKAY;
        end else if (jump_ena) begin
            r_valid <= 1'b0;
            r_pc_if <= 32'h0;
            r_ir_if <= 32'h0;
            r_rresp <= AXI_RESP_OKAY;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_pc_if <= r_araddr;
            r_ir_if <= fetch_word(imem_axi_rdata, imem_axi_rresp);
            r_rresp <= imem_axi_rresp;
        end else if (r_valid && ready_in) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_out         = r_valid;
    assign PC_IF             = r_pc_if;
    assign IR_IF             = r_ir_if;
    assign imem_axi_rresp_IF = r_rresp;
    assign imem_axi_araddr   = r_araddr;
    assign imem_axi_arvalid  = r_arvalid;
    assign imem_axi_arprot   = ARPROT;
    assign imem_axi_rready   = w_rready;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: AXI memory slave, in-order fetch-stream model and directed scenarios.
module tb_if_stage;

    localparam logic [31:0] RV = 32'h00000100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid_out;
    logic        ready_in = 1'b1;
    logic [31:0] PC_IF;
    logic [31:0] IR_IF;
    logic [1:0]  rresp_if;
    logic        jump_ena = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b1;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;

    int errors = 0;
    int checks = 0;
    int delivered = 0;

    if_stage #(.RESET_VEC(RV), .ARPROT(3'b100)) dut (
        .clk(clk), .reset_n(reset_n), .valid_out(valid_out), .ready_in(ready_in),
        .PC_IF(PC_IF), .IR_IF(IR_IF), .imem_axi_rresp_IF(rresp_if),
        .jump_ena(jump_ena), .jump_addr(jump_addr),
        .imem_axi_araddr(araddr), .imem_axi_arprot(arprot), .imem_axi_arvalid(arvalid),
        .imem_axi_arready(arready), .imem_axi_rdata(rdata), .imem_axi_rresp(rresp),
        .imem_axi_rvalid(rvalid), .imem_axi_rready(rready)
    );

    always #5 clk = ~clk;

    // Memory contents and error map.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction
    function automatic logic [1:0] resp_of(input logic [31:0] a);
        if (a[5:2] == 4'h4) return 2'b10;
        if (a[6:2] == 5'h1b) return 2'b11;
        return 2'b00;
    endfunction
    function automatic logic [31:0] exp_ir(input logic [31:0] a);
        return (resp_of(a) == 2'b00) ? mem_word(a) : 32'h00000013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // AXI slave: random arready, response latency in [lat_min, lat_max] cycles after AR.
    int          ar_mode = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    logic        s_pend = 1'b0;
    logic [31:0] s_addr = 32'h0;
    int          s_cnt = 0;
    logic        hs_ar, hs_r;
    logic [31:0] hs_addr;

    always begin
        @(negedge clk);
        hs_ar   = arvalid & arready;
        hs_r    = rvalid & rready;
        hs_addr = araddr;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            rvalid = 1'b0;
            s_pend = 1'b0;
        end else begin
            if (hs_r) rvalid = 1'b0;
            if (hs_ar) begin
                s_pend = 1'b1;
                s_addr = hs_addr;
                s_cnt  = int'($urandom_range(lat_max, lat_min));
            end
            if (s_pend) begin
                if (s_cnt == 0) begin
                    rvalid = 1'b1;
                    rdata  = mem_word(s_addr);
                    rresp  = resp_of(s_addr);
                    s_pend = 1'b0;
                end else begin
                    s_cnt--;
                end
            end
        end
        arready = (ar_mode == 0) ? 1'b1 : (ar_mode == 2) ? 1'b0 : 1'($urandom_range(1));
    end

    // Model: delivered instructions form the sequential stream restarted at each redirect.
    logic [31:0] exp_pc = RV;
    logic        p_valid = 1'b0, p_ready = 1'b0, p_jump = 1'b0, p_arwait = 1'b0;
    logic [31:0] p_pc, p_ir, p_araddr;
    logic [1:0]  p_resp;
    logic [31:0] ar_log[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_pc   = RV;
            p_valid  = 1'b0;
            p_ready  = 1'b0;
            p_jump   = 1'b0;
            p_arwait = 1'b0;
            chk("rst_valid", 32'(valid_out), 32'd0);
            chk("rst_arvalid", 32'(arvalid), 32'd0);
            chk("rst_rready", 32'(rready), 32'd0);
        end else begin
            if (p_jump) begin
                chk("flush_valid", 32'(valid_out), 32'd0);
            end else if (p_valid && !p_ready) begin
                chk("hold_valid", 32'(valid_out), 32'd1);
                chk("hold_pc", PC_IF, p_pc);
                chk("hold_ir", IR_IF, p_ir);
                chk("hold_resp", 32'(rresp_if), 32'(p_resp));
            end
            if (p_arwait) begin
                chk("ar_hold_valid", 32'(arvalid), 32'd1);
                chk("ar_hold_addr", araddr, p_araddr);
            end
            chk("arprot", 32'(arprot), 32'h4);
            if (valid_out && !p_jump && (!p_valid || p_ready)) begin
                chk("item_pc", PC_IF, exp_pc);
                chk("item_ir", IR_IF, exp_ir(exp_pc));
                chk("item_resp", 32'(rresp_if), 32'(resp_of(exp_pc)));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (jump_ena) exp_pc = {jump_addr[31:2], 2'b00};
            if (arvalid && arready) ar_log.push_back(araddr);
            p_valid  = valid_out;
            p_ready  = ready_in;
            p_jump   = jump_ena;
            p_arwait = arvalid & ~arready;
            p_pc     = PC_IF;
            p_ir     = IR_IF;
            p_resp   = rresp_if;
            p_araddr = araddr;
        end
    end

    task automatic wait_item(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            jump_ena = 1'b0;
            if (valid_out) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          n0;
        int          d0;
        logic [31:0] old;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_pc_if", PC_IF, 32'h0);
        chk("rst_ir_if", IR_IF, 32'h0);
        chk("rst_resp_if", 32'(rresp_if), 32'h0);
        chk("rst_araddr", araddr, 32'h0);
        reset_n = 1'b1;

        // Back-to-back fetches from the reset vector, one-cycle R latency.
        step(); chk("first_arvalid", 32'(arvalid), 32'd1); chk("first_araddr", araddr, 32'h100);
        step(); chk("lat_valid_lo", 32'(valid_out), 32'd0);
        step(); chk("lat_valid_hi", 32'(valid_out), 32'd1);
        chk("first_pc", PC_IF, 32'h100); chk("first_ir", IR_IF, 32'hFEFF0100);
        chk("first_resp", 32'(rresp_if), 32'h0);
        step(); chk("pulse_lo0", 32'(valid_out), 32'd0);
        step(); chk("pulse_hi1", 32'(valid_out), 32'd1);
        chk("second_pc", PC_IF, 32'h104); chk("second_ir", IR_IF, 32'hFEFB0104);
        step(); chk("pulse_lo1", 32'(valid_out), 32'd0);
        step(); chk("pulse_hi2", 32'(valid_out), 32'd1); chk("third_pc", PC_IF, 32'h108);
        chk("ar_log_len", 32'(ar_log.size() >= 3), 32'd1);
        if (ar_log.size() >= 3) begin
            chk("ar_seq0", ar_log[0], 32'h100);
            chk("ar_seq1", ar_log[1], 32'h104);
            chk("ar_seq2", ar_log[2], 32'h108);
        end

        // Back-pressure: outputs hold, next beat waits, then delivered.
        ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 32'(valid_out), 32'd1);
            chk("bp_pc", PC_IF, 32'h108);
        end
        chk("bp_rvalid", 32'(rvalid), 32'd1);
        chk("bp_rready", 32'(rready), 32'd0);
        ready_in = 1'b1;
        step(); chk("bp_release_valid", 32'(valid_out), 32'd1); chk("bp_release_pc", PC_IF, 32'h10C);

        // Redirect while waiting for a slow response.
        lat_min = 3; lat_max = 3;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            ok = !arvalid && s_pend;
        end
        chk("swait_reached", 32'(ok), 32'd1);
        n0 = ar_log.size();
        jump_ena = 1'b1; jump_addr = 32'h00000203;
        step(); jump_ena = 1'b0;
        chk("swait_jump_valid", 32'(valid_out), 32'd0);
        wait_item(40, ok);
        chk("swait_item_seen", 32'(ok), 32'd1);
        chk("swait_item_pc", PC_IF, 32'h200);
        chk("swait_item_ir", IR_IF, 32'hFDFF0200);
        chk("swait_next_ar", (ar_log.size() > n0) ? ar_log[n0] : 32'hDEAD, 32'h200);

        // Redirect while the AR is stalled by arready = 0.
        lat_min = 0; lat_max = 0; ar_mode = 2;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            ok = arvalid && !arready;
        end
        chk("sreq_stall_reached", 32'(ok), 32'd1);
        old = araddr;
        n0 = ar_log.size();
        jump_ena = 1'b1; jump_addr = 32'h00000400;
        for (int i = 0; i < 3; i++) begin
            step(); jump_ena = 1'b0;
            chk("sreq_araddr_hold", araddr, old);
            chk("sreq_arvalid_hold", 32'(arvalid), 32'd1);
        end
        ar_mode = 0;
        wait_item(40, ok);
        chk("sreq_item_seen", 32'(ok), 32'd1);
        chk("sreq_item_pc", PC_IF, 32'h400);
        chk("sreq_stale_ar", (ar_log.size() > n0 + 1) ? ar_log[n0] : 32'hDEAD, old);
        chk("sreq_target_ar", (ar_log.size() > n0 + 1) ? ar_log[n0 + 1] : 32'hDEAD, 32'h400);

        // Error response becomes a NOP with the response passed through.
        jump_ena = 1'b1; jump_addr = 32'h00000010;
        wait_item(40, ok);
        chk("err_item_seen", 32'(ok), 32'd1);
        chk("err_pc", PC_IF, 32'h10);
        chk("err_ir", IR_IF, 32'h00000013);
        chk("err_resp", 32'(rresp_if), 32'h2);

        // PC wrap-around.
        n0 = ar_log.size();
        jump_ena = 1'b1; jump_addr = 32'hFFFFFFFC;
        wait_item(40, ok);
        chk("wrap_item0", PC_IF, 32'hFFFFFFFC);
        chk("wrap_ir0", IR_IF, 32'h0003FFFC);
        wait_item(40, ok);
        chk("wrap_item1", PC_IF, 32'h00000000);
        chk("wrap_ir1", IR_IF, 32'hFFFF0000);
        ok = 1'b0;
        for (int k = n0; k + 1 < ar_log.size(); k++) begin
            if (ar_log[k] == 32'hFFFFFFFC && ar_log[k + 1] == 32'h0) ok = 1'b1;
        end
        chk("wrap_ar_seq", 32'(ok), 32'd1);

        // Randomized traffic, stalls and redirects.
        ar_mode = 1; lat_min = 0; lat_max = 3;
        d0 = delivered;
        for (int i = 0; i < 3000; i++) begin
            step();
            ready_in  = ($urandom_range(3) != 0);
            jump_ena  = ($urandom_range(24) == 0);
            jump_addr = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'h000001FF);
        end
        jump_ena = 1'b0;
        chk("random_progress", 32'(delivered - d0 > 100), 32'd1);

        // Asynchronous reset in the middle of a wait.
        ar_mode = 0; lat_min = 3; lat_max = 3; ready_in = 0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            ok = valid_out && !arvalid && (s_pend || rvalid);
        end
        chk("areset_pre_state", 32'(ok), 32'd1);
        ready_in = 1'b1;
        #1;
        chk("areset_pre_rready", 32'(rready), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("areset_arvalid", 32'(arvalid), 32'd0);
        chk("areset_rready", 32'(rready), 32'd0);
        chk("areset_valid", 32'(valid_out), 32'd0);
        repeat (2) step();
        reset_n = 1'b1;
        ar_mode = 1; lat_min = 0; lat_max = 2;
        d0 = delivered;
        for (int i = 0; i < 500; i++) begin
            step();
            ready_in = ($urandom_range(3) != 0);
        end
        chk("post_reset_progress", 32'(delivered - d0 > 20), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
